data_ram_arbiter: RTL and testbench

- Shares one port of the 24-bit image data RAM between two requesters.
  - Requester 0: CPU load/store unit.
  - Requester 1: display/DMA reader.
- Round-robin arbitration with a per-requester lock for bursts.
- Starvation guard breaks a lock held too long.
- Routes the RAM's 1-cycle registered read data back to whichever requester issued the read.

---
 rtl/data_ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one data RAM port between the CPU LSU (req0)
// and the display/DMA reader (req1) using round-robin arbitration.
// A requester may lock the grant for bursts. A starvation guard breaks a
// lock once the other side has waited MAX_WAIT cycles.
// Ports: clock, reset (async, active low);
//   reqN_valid/write/lock/address/wdata in, reqN_ready out;
//   rspN_valid/rdata/error out; lock_broken out;
//   ram_read_enable/write_enable/address/write_data out, ram_read_data in.
// Option: define DATA_RAM_ARB_BOUNDS_EN to reject addresses >= DEPTH
//   with an error response instead of touching the RAM.
module data_ram_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 90000,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_error,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_error,
    output logic                  lock_broken,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        LOCKED0,
        LOCKED1
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t                state;
    state_t                state_next;
    logic                  last_grant;
    logic                  last_grant_next;
    logic [7:0]            wait_count;
    logic [7:0]            wait_count_next;
    logic                  grant0;
    logic                  grant1;
    logic                  break_lock;
    logic                  xfer;
    logic                  win_write;
    logic                  win_lock;
    logic                  win_oob;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  rsp_pending;
    logic                  rsp_owner;
    logic                  rsp_write;
    logic                  rsp_oob;
    logic [DATA_WIDTH-1:0] rdata_gated;

    // Grant decision. Under a lock only the owner is served, unless the
    // waiter has been blocked for MAX_WAIT cycles.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        break_lock = 1'b0;
        unique case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
            end
            LOCKED0: begin
                break_lock = (wait_count == WAIT_LIMIT) && req1_valid;
                grant1     = break_lock;
                grant0     = req0_valid && !break_lock;
            end
            LOCKED1: begin
                break_lock = (wait_count == WAIT_LIMIT) && req0_valid;
                grant0     = break_lock;
                grant1     = req1_valid && !break_lock;
            end
            default: begin
                grant0 = 1'b0;
            end
        endcase
        if (!reset) begin
            grant0     = 1'b0;
            grant1     = 1'b0;
            break_lock = 1'b0;
        end
    end

    assign xfer        = grant0 || grant1;
    assign win_write   = grant1 ? req1_write   : req0_write;
    assign win_lock    = grant1 ? req1_lock    : req0_lock;
    assign win_address = grant1 ? req1_address : req0_address;
    assign win_wdata   = grant1 ? req1_wdata   : req0_wdata;

`ifdef DATA_RAM_ARB_BOUNDS_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    assign win_oob = {1'b0, win_address} >= LIMIT;
`else
    assign win_oob = 1'b0;
`endif

    // The winner's lock bit alone picks the next state, which covers
    // idle grants, owner bursts and a waiter taking over a broken lock.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        wait_count_next = 8'd0;
        if (xfer) begin
            last_grant_next = grant1;
            if (win_lock) begin
                state_next = grant1 ? LOCKED1 : LOCKED0;
            end else begin
                state_next = IDLE;
            end
        end
        if (state == LOCKED0 && req1_valid && !grant1) begin
            wait_count_next = wait_count + 8'd1;
        end
        if (state == LOCKED1 && req0_valid && !grant0) begin
            wait_count_next = wait_count + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wait_count  <= 8'd0;
            rsp_pending <= 1'b0;
            rsp_owner   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_oob     <= 1'b0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            wait_count  <= wait_count_next;
            rsp_pending <= xfer;
            rsp_owner   <= grant1;
            rsp_write   <= win_write;
            rsp_oob     <= win_oob;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign lock_broken = break_lock;

    assign ram_write_enable = xfer && win_write && !win_oob;
    assign ram_read_enable  = xfer && !win_write && !win_oob;
    assign ram_address      = xfer ? win_address : '0;
    assign ram_write_data   = xfer ? win_wdata : '0;

    // Only real reads carry RAM data back; writes and rejected
    // accesses answer with zero.
    assign rdata_gated = (rsp_pending && !rsp_write && !rsp_oob) ?
                         ram_read_data : '0;

    assign rsp0_valid = rsp_pending && !rsp_owner;
    assign rsp1_valid = rsp_pending && rsp_owner;
    assign rsp0_rdata = rsp0_valid ? rdata_gated : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_gated : '0;
    assign rsp0_error = rsp0_valid && rsp_oob;
    assign rsp1_error = rsp1_valid && rsp_oob;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_data_ram_arbiter;

    localparam int AW       = 17;
    localparam int DW       = 24;
    localparam int DEPTH    = 90000;
    localparam int MAX_WAIT = 16;
`ifdef DATA_RAM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid, req0_write, req0_lock;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready, rsp0_valid, rsp0_error;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_write, req1_lock;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready, rsp1_valid, rsp1_error;
    logic [DW-1:0] rsp1_rdata;
    logic          lock_broken, ram_read_enable, ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_write_data, ram_read_data;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    data_ram_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_write(req0_write),
        .req0_lock(req0_lock),
        .req0_address(req0_address),
        .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .rsp0_error(rsp0_error),
        .req1_valid(req1_valid),
        .req1_write(req1_write),
        .req1_lock(req1_lock),
        .req1_address(req1_address),
        .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .rsp1_error(rsp1_error),
        .lock_broken(lock_broken),
        .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable),
        .ram_address(ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data)
    );

    // RAM: unwritten words hold a fixed address-derived pattern.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    bit            ram_wr  [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 40503) ^ 24'h5A5A5A;
    endfunction

    always @(posedge clock) begin
        if (ram_write_enable) begin
            ram_mem[ram_address] <= ram_write_data;
            ram_wr[ram_address]  <= 1'b1;
        end
        if (ram_read_enable) begin
            ram_read_data <= ram_wr[ram_address] ? ram_mem[ram_address]
                                                 : init_word(int'(ram_address));
        end
    end

    task automatic set0(input bit v, input bit w, input bit l,
                        input int a, input logic [DW-1:0] d);
        req0_valid   = v;
        req0_write   = w;
        req0_lock    = l;
        req0_address = AW'(a);
        req0_wdata   = d;
    endtask

    task automatic set1(input bit v, input bit w, input bit l,
                        input int a, input logic [DW-1:0] d);
        req1_valid   = v;
        req1_write   = w;
        req1_lock    = l;
        req1_address = AW'(a);
        req1_wdata   = d;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Transaction-level model: owner (0 none, 1 req0, 2 req1), last
    // winner, blocked-cycle count and the response due next cycle.
    int            m_state, m_last, m_wait, m_po;
    bit            m_pv, m_perr;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_wr  [0:(1<<AW)-1];

    task automatic m_arb(output int win, output bit brk);
        bit v [2];
        int own;
        v[0] = req0_valid;
        v[1] = req1_valid;
        win  = -1;
        brk  = 1'b0;
        if (m_state == 0) begin
            if (v[0] && v[1]) win = 1 - m_last;
            else if (v[0]) win = 0;
            else if (v[1]) win = 1;
        end else begin
            own = m_state - 1;
            if (m_wait == MAX_WAIT && v[1-own]) begin
                brk = 1'b1;
                win = 1 - own;
            end else if (v[own]) begin
                win = own;
            end
        end
    endtask

    task automatic m_commit(input int win, input bit brk);
        bit            w, l, ov;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            oth;
        oth = 2 - m_state;
        ov  = (oth == 0) ? req0_valid : req1_valid;
        if (m_state != 0 && !brk && ov && win != oth) m_wait++;
        else m_wait = 0;
        m_pv = (win >= 0);
        if (win >= 0) begin
            w = (win == 1) ? req1_write : req0_write;
            l = (win == 1) ? req1_lock : req0_lock;
            a = (win == 1) ? req1_address : req0_address;
            d = (win == 1) ? req1_wdata : req0_wdata;
            m_po    = win;
            m_perr  = BOUNDS && (int'(a) >= DEPTH);
            m_pdata = (w || m_perr) ? DW'(0) :
                      (ref_wr[a] ? ref_mem[a] : init_word(int'(a)));
            if (w && !m_perr) begin
                ref_mem[a] = d;
                ref_wr[a]  = 1'b1;
            end
            m_last  = win;
            m_state = l ? win + 1 : 0;
        end
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 2))
            0: return 256 + int'($urandom_range(0, 15));
            1: return 89980 + int'($urandom_range(0, 18));
            default: return 90001 + int'($urandom_range(0, 19));
        endcase
    endfunction

    task automatic test_reset();
        logic [6:0]          ctl;
        logic [4*DW+2*AW:0]  outs;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        @(negedge clock);
        set0(1, 0, 0, 16, 0);
        #1;
        ctl = {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               lock_broken, ram_read_enable, ram_write_enable};
        total++;
        if (ctl !== 7'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b want 0000000", ctl);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({req0_ready, ram_read_enable, ram_address} !== {2'b11, AW'(16)}) begin
            bad++;
            $display("FAIL reset_accept: ready=%b re=%b addr=%h want 1 1 00010",
                     req0_ready, ram_read_enable, ram_address);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        set0(0, 0, 0, 0, 0);
        #1;
        total++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b0, DW'(0)}) begin
            bad++;
            $display("FAIL reset_drop: rsp0_valid=%b rdata=%h want 0 0",
                     rsp0_valid, rsp0_rdata);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        outs = {req0_ready, req1_ready, rsp0_valid, rsp0_error, rsp0_rdata,
                rsp1_valid, rsp1_error, rsp1_rdata, lock_broken,
                ram_read_enable, ram_write_enable, ram_address, ram_write_data};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_idle: outputs=%h want 0", outs);
        end
    endtask

    task automatic test_tie_break();
        int            g;
        logic [DW-1:0] got;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clock);
            set0(c < 4, 0, 0, 1, 0);
            set1(c < 4, 0, 0, 2, 0);
            #1;
            if (c < 4) begin
                total++;
                if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL tie_grant c=%0d: got %b%b want %0d",
                             c, req0_ready, req1_ready, c % 2);
                end
            end
            if (c > 0) begin
                g   = (c - 1) % 2;
                got = (g == 0) ? rsp0_rdata : rsp1_rdata;
                total++;
                if ({rsp0_valid, rsp1_valid} !== ((g == 0) ? 2'b10 : 2'b01) ||
                    got !== init_word(g + 1)) begin
                    bad++;
                    $display("FAIL tie_rsp c=%0d: v=%b%b data=%h want owner %0d data %h",
                             c, rsp0_valid, rsp1_valid, got, g, init_word(g + 1));
                end
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clock);
        set0(1, 1, 0, 'h15F8F, 24'hABCDEF);
        #1;
        total++;
        if ({req0_ready, ram_write_enable, ram_address, ram_write_data} !==
            {2'b11, AW'('h15F8F), 24'hABCDEF}) begin
            bad++;
            $display("FAIL wr_drive: rdy=%b we=%b a=%h d=%h want 1 1 15f8f abcdef",
                     req0_ready, ram_write_enable, ram_address, ram_write_data);
        end
        @(negedge clock);
        set0(1, 0, 0, 'h15F8F, 0);
        #1;
        total++;
        if ({req0_ready, ram_read_enable, rsp0_valid, rsp0_rdata} !==
            {3'b111, DW'(0)}) begin
            bad++;
            $display("FAIL wr_rsp: rdy=%b re=%b v=%b d=%h want 1 1 1 0",
                     req0_ready, ram_read_enable, rsp0_valid, rsp0_rdata);
        end
        @(negedge clock);
        set0(0, 0, 0, 0, 0);
        #1;
        total++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 24'hABCDEF}) begin
            bad++;
            $display("FAIL rd_rsp: v=%b d=%h want 1 abcdef", rsp0_valid, rsp0_rdata);
        end
    endtask

    task automatic test_lock_release();
        do_reset();
        @(negedge clock);
        set0(1, 0, 0, 5, 0);
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL lock_pre: ready0=%b want 1", req0_ready);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            set0(1, 0, 0, 6, 0);
            set1(1, 0, c < 4, 32 + c, 0);
            #1;
            total++;
            if ({req0_ready, req1_ready, lock_broken} !== ((c < 5) ? 3'b010 : 3'b100)) begin
                bad++;
                $display("FAIL lock_seq c=%0d: r0 r1 lb=%b%b%b want %b", c,
                         req0_ready, req1_ready, lock_broken, (c < 5) ? 3'b010 : 3'b100);
            end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] want;
        do_reset();
        @(negedge clock);
        set1(1, 0, 1, 48, 0);
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL starve_pre: ready1=%b want 1", req1_ready);
        end
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            set0(1, 0, 0, 49, 0);
            set1(1, 0, 1, 48, 0);
            #1;
            want = (c == 17) ? 3'b101 : 3'b010;
            total++;
            if ({req0_ready, req1_ready, lock_broken} !== want) begin
                bad++;
                $display("FAIL starve c=%0d: r0 r1 lb=%b%b%b want %b", c,
                         req0_ready, req1_ready, lock_broken, want);
            end
        end
    endtask

    task automatic test_release_at_max();
        logic [2:0] want;
        do_reset();
        @(negedge clock);
        set1(1, 0, 1, 64, 0);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            set0(1, 0, 0, 65, 0);
            set1(1, 0, c < 16, 64, 0);
            #1;
            want = (c <= 16) ? 3'b010 : 3'b100;
            total++;
            if ({req0_ready, req1_ready, lock_broken} !== want) begin
                bad++;
                $display("FAIL release_max c=%0d: r0 r1 lb=%b%b%b want %b", c,
                         req0_ready, req1_ready, lock_broken, want);
            end
        end
    endtask

    task automatic test_owner_idle();
        logic [2:0] want;
        do_reset();
        @(negedge clock);
        set1(1, 0, 1, 7, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            set0(c >= 3, 0, 0, 8, 0);
            set1(c == 5, 0, 0, 7, 0);
            #1;
            want = (c == 5) ? 3'b010 : (c == 6) ? 3'b100 : 3'b000;
            total++;
            if ({req0_ready, req1_ready, lock_broken} !== want) begin
                bad++;
                $display("FAIL owner_idle c=%0d: r0 r1 lb=%b%b%b want %b", c,
                         req0_ready, req1_ready, lock_broken, want);
            end
        end
    endtask

    task automatic test_bounds();
        logic [2:0]      ctl_want [5];
        logic [DW+1:0]   rsp_want [5];
        ctl_want[0] = 3'b110;
        ctl_want[1] = {1'b1, !BOUNDS, 1'b0};
        ctl_want[2] = {1'b1, 1'b0, !BOUNDS};
        ctl_want[3] = 3'b101;
        ctl_want[4] = 3'b000;
        rsp_want[1] = {2'b10, DW'(0)};
        rsp_want[2] = {1'b1, BOUNDS, DW'(0)};
        rsp_want[3] = {1'b1, BOUNDS, BOUNDS ? DW'(0) : 24'h777777};
        rsp_want[4] = {2'b10, 24'h123456};
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clock);
            case (c)
                0: set0(1, 1, 0, 89999, 24'h123456);
                1: set0(1, 1, 0, 90000, 24'h777777);
                2: set0(1, 0, 0, 90000, 0);
                3: set0(1, 0, 0, 89999, 0);
                default: set0(0, 0, 0, 0, 0);
            endcase
            #1;
            total++;
            if ({req0_ready, ram_write_enable, ram_read_enable} !== ctl_want[c]) begin
                bad++;
                $display("FAIL bounds_ram c=%0d: rdy we re=%b%b%b want %b", c,
                         req0_ready, ram_write_enable, ram_read_enable, ctl_want[c]);
            end
            if (c > 0) begin
                total++;
                if ({rsp0_valid, rsp0_error, rsp0_rdata} !== rsp_want[c]) begin
                    bad++;
                    $display("FAIL bounds_rsp c=%0d: got %h want %h", c,
                             {rsp0_valid, rsp0_error, rsp0_rdata}, rsp_want[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit            pv [2];
        bit            pw [2];
        bit            pl [2];
        int            pa [2];
        logic [DW-1:0] pd [2];
        int            win, wi, lock_pct, breaks;
        bit            brk, cw, co;
        logic [8:0]    exp_ctl, got_ctl;
        logic [AW+DW-1:0] exp_bus, got_bus;
        logic [2*DW-1:0]  exp_rd, got_rd;
        do_reset();
        m_state = 0;
        m_last  = 1;
        m_wait  = 0;
        m_pv    = 1'b0;
        breaks  = 0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            lock_pct = (i < 500) ? 0 : (i < 1000) ? 40 : 95;
            @(negedge clock);
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && i < 1495 && $urandom_range(0, 99) < 70) begin
                    pv[r] = 1'b1;
                    pw[r] = ($urandom_range(0, 2) == 0);
                    pl[r] = ($urandom_range(0, 99) < lock_pct);
                    pa[r] = rand_addr();
                    pd[r] = DW'($urandom);
                end
            end
            set0(pv[0], pw[0], pl[0], pa[0], pd[0]);
            set1(pv[1], pw[1], pl[1], pa[1], pd[1]);
            #1;
            m_arb(win, brk);
            wi = (win == 1) ? 1 : 0;
            cw = (win >= 0) && pw[wi];
            co = (win >= 0) && BOUNDS && (pa[wi] >= DEPTH);
            exp_ctl = {win == 0, win == 1, brk,
                       (win >= 0) && !cw && !co, cw && !co,
                       m_pv && m_po == 0, m_pv && m_po == 0 && m_perr,
                       m_pv && m_po == 1, m_pv && m_po == 1 && m_perr};
            got_ctl = {req0_ready, req1_ready, lock_broken,
                       ram_read_enable, ram_write_enable,
                       rsp0_valid, rsp0_error, rsp1_valid, rsp1_error};
            exp_bus = (win >= 0) ? {AW'(pa[wi]), pd[wi]} : '0;
            got_bus = {ram_address, ram_write_data};
            exp_rd  = {(m_pv && m_po == 0) ? m_pdata : DW'(0),
                       (m_pv && m_po == 1) ? m_pdata : DW'(0)};
            got_rd  = {rsp0_rdata, rsp1_rdata};
            total++;
            if (got_ctl !== exp_ctl) begin
                bad++;
                $display("FAIL rand_ctl i=%0d: got %b want %b", i, got_ctl, exp_ctl);
            end
            total++;
            if (got_bus !== exp_bus) begin
                bad++;
                $display("FAIL rand_bus i=%0d: got %h want %h", i, got_bus, exp_bus);
            end
            total++;
            if (got_rd !== exp_rd) begin
                bad++;
                $display("FAIL rand_rdata i=%0d: got %h want %h", i, got_rd, exp_rd);
            end
            if (brk) breaks++;
            if (req0_ready) pv[0] = 1'b0;
            if (req1_ready) pv[1] = 1'b0;
            m_commit(win, brk);
        end
        $display("random traffic: lock breaks seen=%0d", breaks);
    endtask

    initial begin
        test_reset();
        test_tie_break();
        test_write_read();
        test_lock_release();
        test_starvation();
        test_release_at_max();
        test_owner_idle();
        test_bounds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
